// File: rtl/cpu_controller.sv
// cpu_controller: Moore sequencer for the lab CPU datapath.
// Steps one instruction per start strobe through the register-file reads,
// ALU and write-back, driving every load/select/write strobe and the w flag.
//
//   state       | meaning
//   ------------+-----------------------------------------------------
//   S_WAIT      | idle, w=1, waiting for s
//   S_DECODE    | branch on {opcode,op}; latch captured on exit
//   S_WRITE_IMM | write sximm8 into Rn
//   S_GET_A     | read Rn into A
//   S_GET_B     | read Rm into B
//   S_ALU       | load C (or status for cmp)
//   S_WRITE_REG | write C into Rd
module cpu_controller (
  input  logic       clk,
  input  logic       reset,
  input  logic       s,
  input  logic [2:0] opcode,
  input  logic [1:0] op,
  output logic       w,
  output logic [2:0] nsel,
  output logic [1:0] vsel,
  output logic       loada,
  output logic       loadb,
  output logic       loadc,
  output logic       loads,
  output logic       asel,
  output logic       bsel,
  output logic       write
);

  typedef enum logic [2:0] {
    S_WAIT      = 3'd0,
    S_DECODE    = 3'd1,
    S_WRITE_IMM = 3'd2,
    S_GET_A     = 3'd3,
    S_GET_B     = 3'd4,
    S_ALU       = 3'd5,
    S_WRITE_REG = 3'd6
  } state_t;

  localparam logic [2:0] NSEL_RN   = 3'b100;
  localparam logic [2:0] NSEL_RD   = 3'b010;
  localparam logic [2:0] NSEL_RM   = 3'b001;
  localparam logic [1:0] VSEL_C    = 2'b00;
  localparam logic [1:0] VSEL_IMM8 = 2'b10;

  state_t     state;
  state_t     state_next;
  logic [4:0] instr_q;
  logic       is_cmp;
  logic       is_mov;

  // The latch isolates the rest of the sequence from instruction-register changes.
  assign is_cmp = (instr_q == 5'b101_01);
  assign is_mov = (instr_q[4:2] == 3'b110);

  // State register and instruction latch; latch loads on the edge leaving Decode.
  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= S_WAIT;
      instr_q <= 5'b00000;
    end else begin
      state <= state_next;
      if (state == S_DECODE) begin
        instr_q <= {opcode, op};
      end
    end
  end

  // Next-state decode; Decode branches on the live inputs, later states on the latch.
  always_comb begin
    state_next = S_WAIT;
    case (state)
      S_WAIT:      state_next = s ? S_DECODE : S_WAIT;
      S_DECODE: begin
        casez ({opcode, op})
          5'b110_10: state_next = S_WRITE_IMM;
          5'b110_00: state_next = S_GET_B;
          5'b101_??: state_next = S_GET_A;
          default:   state_next = S_WAIT;
        endcase
      end
      S_WRITE_IMM: state_next = S_WAIT;
      S_GET_A:     state_next = S_GET_B;
      S_GET_B:     state_next = S_ALU;
      S_ALU:       state_next = is_cmp ? S_WAIT : S_WRITE_REG;
      S_WRITE_REG: state_next = S_WAIT;
      default:     state_next = S_WAIT;
    endcase
  end

  // Moore output decode; reset overrides so no strobe can fire on the reset edge.
  always_comb begin
    w     = 1'b0;
    nsel  = 3'b000;
    vsel  = VSEL_C;
    loada = 1'b0;
    loadb = 1'b0;
    loadc = 1'b0;
    loads = 1'b0;
    asel  = 1'b0;
    bsel  = 1'b0;
    write = 1'b0;
    case (state)
      S_WAIT: w = 1'b1;
      S_WRITE_IMM: begin
        nsel  = NSEL_RN;
        vsel  = VSEL_IMM8;
        write = 1'b1;
      end
      S_GET_A: begin
        nsel  = NSEL_RN;
        loada = 1'b1;
      end
      S_GET_B: begin
        nsel  = NSEL_RM;
        loadb = 1'b1;
      end
      S_ALU: begin
        loadc = ~is_cmp;
        loads = is_cmp;
        asel  = is_mov;
      end
      S_WRITE_REG: begin
        nsel  = NSEL_RD;
        vsel  = VSEL_C;
        write = 1'b1;
      end
      default: ;
    endcase
    if (reset) begin
      w     = 1'b1;
      nsel  = 3'b000;
      vsel  = VSEL_C;
      loada = 1'b0;
      loadb = 1'b0;
      loadc = 1'b0;
      loads = 1'b0;
      asel  = 1'b0;
      bsel  = 1'b0;
      write = 1'b0;
    end
  end

endmodule

// File: tb/tb_cpu_controller.sv
// Testbench for cpu_controller: directed steps then random instructions,
// each checked cycle by cycle against an instruction-level reference model.
module tb_cpu_controller;

  logic       clk;
  logic       reset;
  logic       s;
  logic [2:0] opcode;
  logic [1:0] op;
  logic       w;
  logic [2:0] nsel;
  logic [1:0] vsel;
  logic       loada, loadb, loadc, loads, asel, bsel, write;

  int errors = 0;
  int checks = 0;

  logic [12:0] obs;
  logic [12:0] exp_q[$];

  cpu_controller dut (
    .clk(clk), .reset(reset), .s(s), .opcode(opcode), .op(op),
    .w(w), .nsel(nsel), .vsel(vsel), .loada(loada), .loadb(loadb),
    .loadc(loadc), .loads(loads), .asel(asel), .bsel(bsel), .write(write)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  assign obs = {w, nsel, vsel, loada, loadb, loadc, loads, asel, bsel, write};

  // Output vector packing: {w, nsel, vsel, loada, loadb, loadc, loads, asel, bsel, write}
  function automatic logic [12:0] mk(input logic wf, input logic [2:0] ns, input logic [1:0] vs,
                                     input logic la, input logic lb, input logic lc,
                                     input logic ls, input logic as, input logic wr);
    return {wf, ns, vs, la, lb, lc, ls, as, 1'b0, wr};
  endfunction

  localparam logic [12:0] WAIT_V = 13'b1_000_00_0000000;

  // Reference: per-cycle outputs from the Decode cycle until the return to Wait.
  function automatic void build_expect(input logic [2:0] opc, input logic [1:0] o);
    exp_q.delete();
    exp_q.push_back(mk(0, 3'b000, 2'b00, 0, 0, 0, 0, 0, 0));
    if (opc == 3'b110 && o == 2'b10) begin
      exp_q.push_back(mk(0, 3'b100, 2'b10, 0, 0, 0, 0, 0, 1));
    end else if (opc == 3'b110 && o == 2'b00) begin
      exp_q.push_back(mk(0, 3'b001, 2'b00, 0, 1, 0, 0, 0, 0));
      exp_q.push_back(mk(0, 3'b000, 2'b00, 0, 0, 1, 0, 1, 0));
      exp_q.push_back(mk(0, 3'b010, 2'b00, 0, 0, 0, 0, 0, 1));
    end else if (opc == 3'b101) begin
      exp_q.push_back(mk(0, 3'b100, 2'b00, 1, 0, 0, 0, 0, 0));
      exp_q.push_back(mk(0, 3'b001, 2'b00, 0, 1, 0, 0, 0, 0));
      if (o == 2'b01) begin
        exp_q.push_back(mk(0, 3'b000, 2'b00, 0, 0, 0, 1, 0, 0));
      end else begin
        exp_q.push_back(mk(0, 3'b000, 2'b00, 0, 0, 1, 0, 0, 0));
        exp_q.push_back(mk(0, 3'b010, 2'b00, 0, 0, 0, 0, 0, 1));
      end
    end
  endfunction

  task automatic check(input string tag, input logic [12:0] got, input logic [12:0] want);
    checks++;
    assert (got === want) else begin
      errors++;
      $error("FAIL %s observed=%b expected=%b", tag, got, want);
    end
  endtask

  task automatic idle(input int n);
    s = 1'b0;
    repeat (n) begin
      @(negedge clk);
      check("idle_wait", obs, WAIT_V);
      @(posedge clk); #1;
    end
  endtask

  // Runs one instruction starting from Wait. scr: 0 hold inputs, 1 force opcode 111
  // after Decode, 2 randomize inputs after Decode. abort_at: cycle index to assert reset.
  task automatic run(input logic [2:0] opc, input logic [1:0] o, input int scr, input int abort_at);
    build_expect(opc, o);
    opcode = opc;
    op     = o;
    s      = 1'b1;
    @(negedge clk);
    check("start_wait", obs, WAIT_V);
    @(posedge clk); #1;
    for (int i = 0; i < exp_q.size(); i++) begin
      if (i > 0 && scr == 1) begin
        opcode = 3'b111;
        op     = 2'($urandom);
      end else if (i > 0 && scr == 2) begin
        opcode = 3'($urandom);
        op     = 2'($urandom);
        s      = 1'($urandom);
      end
      if (i == abort_at) begin
        reset = 1'b1;
        @(negedge clk);
        check("abort_gate", obs, WAIT_V);
        @(posedge clk); #1;
        reset = 1'b0;
        s     = 1'b0;
        @(negedge clk);
        check("abort_wait", obs, WAIT_V);
        @(posedge clk); #1;
        return;
      end
      @(negedge clk);
      check($sformatf("seq_%0b_%0b_c%0d", opc, o, i), obs, exp_q[i]);
      @(posedge clk); #1;
    end
    s = 1'b0;
  endtask

  initial begin
    reset  = 1'b1;
    s      = 1'b0;
    opcode = 3'b000;
    op     = 2'b00;
    #1;
    repeat (3) begin
      @(negedge clk);
      check("reset", obs, WAIT_V);
      @(posedge clk); #1;
    end
    reset = 1'b0;
    idle(1);

    run(3'b110, 2'b10, 0, -1);
    idle(1);
    run(3'b101, 2'b00, 0, -1);
    idle(1);
    run(3'b101, 2'b01, 0, -1);
    idle(1);
    run(3'b110, 2'b00, 1, -1);
    idle(1);
    run(3'b000, 2'b00, 0, -1);
    idle(1);
    run(3'b101, 2'b00, 0, 4);
    idle(2);

    run(3'b110, 2'b10, 0, -1);
    run(3'b101, 2'b00, 0, -1);
    run(3'b101, 2'b01, 0, -1);
    idle(2);

    for (int k = 0; k < 60; k++) begin
      logic [2:0] ro;
      logic [1:0] rp;
      int ab;
      ro = 3'($urandom);
      rp = 2'($urandom);
      if ($urandom_range(0, 2) == 0) ro = 3'b101;
      if ($urandom_range(0, 2) == 0) ro = 3'b110;
      ab = ($urandom_range(0, 7) == 0) ? int'($urandom_range(0, 4)) : -1;
      run(ro, rp, int'($urandom_range(0, 2)), ab);
      if ($urandom_range(0, 1) == 1) idle(int'($urandom_range(1, 2)));
    end
    idle(1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
